// File: rtl/sd_resp_pkg.sv
// rtl/sd_resp_pkg.sv - shared state encoding and sector geometry for the sector responder
package sd_resp_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_FETCH,
    RD_STROBE,
    WR_ADDR,
    WR_SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/sd_block_responder_if.sv
// rtl/sd_block_responder_if.sv - core-side sector handshake and buffer port
interface sd_block_responder_if;
  import sd_resp_pkg::*;

  logic [31:0]          sd_lba;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 sd_ack;
  logic [SECTOR_AW-1:0] sd_buff_addr;
  logic [7:0]           sd_buff_dout;
  logic                 sd_buff_wr;
  logic [7:0]           sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

endinterface

// File: rtl/sd_sector_stream.sv
// rtl/sd_sector_stream.sv - byte index and inter-byte gap counter for one sector
module sd_sector_stream
  import sd_resp_pkg::*;
#(
  parameter int BYTE_GAP = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 hold_i,
  output logic [SECTOR_AW-1:0] idx_o,
  output logic                 first_o,
  output logic                 step_o,
  output logic                 last_o
);

  localparam int GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;

  logic [SECTOR_AW-1:0] idx_q;
  logic [GW-1:0]        gap_q;

  // hold_i marks the second phase of a byte; it lasts 1+BYTE_GAP cycles
  assign first_o = (gap_q == '0);
  assign step_o  = hold_i && (gap_q == GW'(BYTE_GAP));
  assign last_o  = (idx_q == SECTOR_AW'(SECTOR_BYTES - 1));
  assign idx_o   = idx_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      gap_q <= '0;
    end else begin
      if (clr_i)
        idx_q <= '0;
      else if (step_o && !last_o)
        idx_q <= idx_q + SECTOR_AW'(1);
      if (hold_i && !step_o)
        gap_q <= gap_q + GW'(1);
      else
        gap_q <= '0;
    end
  end

endmodule

// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - answers 512-byte sector read/write requests from a byte-wide store
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int LBA_W     = 4,
  parameter int ACK_DELAY = 4,
  parameter int BYTE_GAP  = 0
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  sd_block_responder_if.slave        sd,
  output logic [LBA_W+SECTOR_AW-1:0] store_addr,
  output logic                       store_rd,
  input  logic [7:0]                 store_din,
  output logic                       store_wr,
  output logic [7:0]                 store_dout,
  output logic                       busy,
  output logic                       err
);

  localparam int WW = $clog2(ACK_DELAY) + 1;

  state_t                     state_q;
  logic [LBA_W-1:0]           lba_q;
  logic                       rd_q;
  logic [WW-1:0]              wait_q;
  logic                       ack_q, busy_q, err_q;
  logic                       store_rd_q, store_wr_q, buff_wr_q;
  logic [SECTOR_AW-1:0]       buff_addr_q;
  logic [7:0]                 buff_dout_q, store_dout_q;
  logic [LBA_W+SECTOR_AW-1:0] store_addr_q;

  logic                 clr, hold, first, step, last;
  logic [SECTOR_AW-1:0] idx, idx_nxt;

  assign clr     = (state_q == IDLE) || (state_q == WAIT);
  assign hold    = (state_q == RD_STROBE) || (state_q == WR_SAMPLE);
  assign idx_nxt = idx + SECTOR_AW'(1);

  sd_sector_stream #(.BYTE_GAP(BYTE_GAP)) u_stream (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr_i   (clr),
    .hold_i  (hold),
    .idx_o   (idx),
    .first_o (first),
    .step_o  (step),
    .last_o  (last)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lba_q        <= '0;
      rd_q         <= 1'b0;
      wait_q       <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      store_rd_q   <= 1'b0;
      store_wr_q   <= 1'b0;
      buff_wr_q    <= 1'b0;
      buff_addr_q  <= '0;
      buff_dout_q  <= '0;
      store_dout_q <= '0;
      store_addr_q <= '0;
    end else begin
      store_rd_q <= 1'b0;
      store_wr_q <= 1'b0;
      buff_wr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // read wins when both requests are raised together
          if (sd.sd_rd || sd.sd_wr) begin
            state_q <= WAIT;
            lba_q   <= sd.sd_lba[LBA_W-1:0];
            rd_q    <= sd.sd_rd;
            err_q   <= |sd.sd_lba[31:LBA_W];
            busy_q  <= 1'b1;
            wait_q  <= '0;
          end
        end
        WAIT: begin
          if (wait_q == WW'(ACK_DELAY - 1)) begin
            ack_q <= 1'b1;
            if (rd_q) begin
              state_q      <= RD_FETCH;
              store_rd_q   <= 1'b1;
              store_addr_q <= {lba_q, {SECTOR_AW{1'b0}}};
            end else begin
              state_q     <= WR_ADDR;
              buff_addr_q <= '0;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        RD_FETCH: state_q <= RD_STROBE;
        RD_STROBE: begin
          // store_din answers the fetch during the first cycle of this state only
          if (first) begin
            buff_wr_q   <= 1'b1;
            buff_addr_q <= idx;
            buff_dout_q <= err_q ? 8'hFF : store_din;
          end
          if (step) begin
            if (last) begin
              state_q <= DONE;
            end else begin
              state_q      <= RD_FETCH;
              store_rd_q   <= 1'b1;
              store_addr_q <= {lba_q, idx_nxt};
            end
          end
        end
        WR_ADDR: state_q <= WR_SAMPLE;
        WR_SAMPLE: begin
          if (first) begin
            store_dout_q <= sd.sd_buff_din;
            store_addr_q <= {lba_q, idx};
            store_wr_q   <= !err_q;
          end
          if (step) begin
            if (last) begin
              state_q <= DONE;
            end else begin
              state_q     <= WR_ADDR;
              buff_addr_q <= idx_nxt;
            end
          end
        end
        DONE: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = buff_addr_q;
  assign sd.sd_buff_dout = buff_dout_q;
  assign sd.sd_buff_wr   = buff_wr_q;
  assign store_addr      = store_addr_q;
  assign store_rd        = store_rd_q;
  assign store_wr        = store_wr_q;
  assign store_dout      = store_dout_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// tb/tb_sd_block_responder.sv - randomized self-checking bench for sd_block_responder
module tb_sd_block_responder;

  localparam int LBA_W     = 4;
  localparam int ACK_DELAY = 4;
  localparam int BYTE_GAP  = 0;
  localparam int NADDR     = (1 << LBA_W) * 512;
  localparam int SEC_CYC   = ACK_DELAY + 512 * (2 + BYTE_GAP) + 1;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [LBA_W+8:0] store_addr;
  logic             store_rd, store_wr, busy, err;
  logic [7:0]       store_din = 8'h00;
  logic [7:0]       store_dout;

  sd_block_responder_if bus ();

  sd_block_responder #(.LBA_W(LBA_W), .ACK_DELAY(ACK_DELAY), .BYTE_GAP(BYTE_GAP)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sd         (bus.slave),
    .store_addr (store_addr),
    .store_rd   (store_rd),
    .store_din  (store_din),
    .store_wr   (store_wr),
    .store_dout (store_dout),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0]  mem     [0:NADDR-1];
  int          wcount  [0:NADDR-1];
  int          snap    [0:NADDR-1];
  logic [7:0]  exp_mem [0:NADDR-1];
  logic [7:0]  wbuf    [0:511];
  logic [16:0] bw_log  [$];
  int n_cmp = 0, n_mis = 0;
  int buff_wr_cnt = 0, store_wr_cnt = 0, store_rd_cnt = 0;

  // backing store (unwritten bytes read as addr^0x5A) and core buffer models
  always @(posedge clk_sys) begin
    if (store_rd) begin
      store_din <= (wcount[store_addr] != 0) ? mem[store_addr] : (store_addr[7:0] ^ 8'h5A);
      store_rd_cnt++;
    end
    if (store_wr) begin
      mem[store_addr] <= store_dout;
      wcount[store_addr] = wcount[store_addr] + 1;
      store_wr_cnt++;
    end
    if (bus.sd_buff_wr) begin
      bw_log.push_back({bus.sd_buff_addr, bus.sd_buff_dout});
      buff_wr_cnt++;
    end
    bus.sd_buff_din <= wbuf[bus.sd_buff_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, bus.sd_ack, busy, err, store_wr, store_rd, bus.sd_buff_wr,
            bus.sd_buff_addr, bus.sd_buff_dout, store_addr, store_dout};
  endfunction

  task automatic run_sector(input logic rd, input logic wr, input logic [31:0] lba,
                            output int t_ack, output int t_fall);
    int c;
    t_ack = -1;
    t_fall = -1;
    bus.sd_lba = lba;
    bus.sd_rd = rd;
    bus.sd_wr = wr;
    c = 0;
    while (!busy && c < 50) begin @(posedge clk_sys); #1; c++; end
    if (!busy) begin
      chk("accept_timeout", 0, 1);
      bus.sd_rd = 1'b0;
      bus.sd_wr = 1'b0;
      return;
    end
    c = 0;
    while (!bus.sd_ack && c < 100) begin @(posedge clk_sys); #1; c++; end
    t_ack = c;
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    while (bus.sd_ack && c < 4 * SEC_CYC) begin @(posedge clk_sys); #1; c++; end
    t_fall = c;
  endtask

  task automatic verify_read(input string tag, input int base, input int lba, input bit all_ff);
    int bad;
    logic [16:0] want;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      want = {9'(k), all_ff ? 8'hFF : exp_mem[lba * 512 + k]};
      if (bw_log[base + k] !== want) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic verify_sector(input string tag, input int lba);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[lba * 512 + i] !== exp_mem[lba * 512 + i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic read_and_check(input string tag, input logic [31:0] lba, input bit rd_and_wr);
    int ta, tf, b0, bw0, sw0, lsec;
    bit oor;
    oor = (lba >= 32'(1 << LBA_W));
    lsec = int'(lba[LBA_W-1:0]);
    b0 = bw_log.size();
    bw0 = buff_wr_cnt;
    sw0 = store_wr_cnt;
    run_sector(1'b1, rd_and_wr, lba, ta, tf);
    chk({tag, "_ack_delay"}, ta, ACK_DELAY);
    chk({tag, "_latency"}, tf, SEC_CYC);
    chk({tag, "_strobes"}, buff_wr_cnt - bw0, 512);
    chk({tag, "_store_wr"}, store_wr_cnt - sw0, 0);
    verify_read({tag, "_data"}, b0, lsec, oor);
    chk({tag, "_busy_err"}, {busy, err}, {1'b0, oor});
  endtask

  task automatic write_and_check(input string tag, input logic [31:0] lba);
    int ta, tf, bw0, sw0, sr0, lsec;
    bit oor;
    oor = (lba >= 32'(1 << LBA_W));
    lsec = int'(lba[LBA_W-1:0]);
    bw0 = buff_wr_cnt;
    sw0 = store_wr_cnt;
    sr0 = store_rd_cnt;
    run_sector(1'b0, 1'b1, lba, ta, tf);
    if (!oor)
      for (int i = 0; i < 512; i++) exp_mem[lsec * 512 + i] = wbuf[i];
    chk({tag, "_store_wr"}, store_wr_cnt - sw0, oor ? 0 : 512);
    chk({tag, "_no_rd_side"}, {buff_wr_cnt - bw0, store_rd_cnt - sr0}, 0);
    chk({tag, "_busy_err"}, {busy, err}, {1'b0, oor});
    if (!oor) verify_sector({tag, "_mem"}, lsec);
  endtask

  initial begin
    int c, sw0, bad;
    for (int a = 0; a < NADDR; a++) exp_mem[a] = 8'(a) ^ 8'h5A;
    for (int i = 0; i < 512; i++) wbuf[i] = 8'h00;
    bus.sd_lba = 32'd0;
    bus.sd_rd  = 1'b0;
    bus.sd_wr  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    chk("idle_outputs", outs(), 64'd0);

    read_and_check("rd3", 32'd3, 1'b0);

    for (int i = 0; i < 512; i++) wbuf[i] = 8'(i);
    write_and_check("wr2", 32'd2);

    // core-style save of every sector with fresh random buffer contents
    for (int a = 0; a < NADDR; a++) snap[a] = wcount[a];
    sw0 = store_wr_cnt;
    for (int s = 0; s < (1 << LBA_W); s++) begin
      int ta, tf;
      for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
      for (int i = 0; i < 512; i++) exp_mem[s * 512 + i] = wbuf[i];
      run_sector(1'b0, 1'b1, 32'(s), ta, tf);
    end
    chk("save_total_wr", store_wr_cnt - sw0, NADDR);
    bad = 0;
    for (int a = 0; a < NADDR; a++) if (wcount[a] != snap[a] + 1) bad++;
    chk("save_once_each", bad, 0);
    bad = 0;
    for (int a = 0; a < NADDR; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk("save_contents", bad, 0);

    for (int r = 0; r < 4; r++)
      read_and_check("rd_rand", 32'($urandom_range(0, (1 << LBA_W) - 1)), 1'b0);

    read_and_check("rdwr1", 32'd1, 1'b1);

    read_and_check("oor_rd16", 32'd16, 1'b0);
    for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
    write_and_check("oor_wr", 32'd16 + 32'($urandom_range(0, 100000)));
    read_and_check("rd0_after_err", 32'd0, 1'b0);

    // abort a write by reset just after its 100th store write
    for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
    sw0 = store_wr_cnt;
    bus.sd_lba = 32'd0;
    bus.sd_wr = 1'b1;
    c = 0;
    while (store_wr_cnt - sw0 < 100 && c < 2000) begin
      @(posedge clk_sys); #1; c++;
      if (bus.sd_ack) bus.sd_wr = 1'b0;
    end
    bus.sd_wr = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_outputs", outs(), 64'd0);
    chk("abort_wr_count", store_wr_cnt - sw0, 100);
    repeat (5) @(posedge clk_sys);
    #1;
    chk("abort_wr_held", store_wr_cnt - sw0, 100);
    for (int i = 0; i < 100; i++) exp_mem[i] = wbuf[i];
    reset = 1'b0;
    @(posedge clk_sys); #1;
    read_and_check("rd0_after_abort", 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
